// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side request/response and data-memory strobe bundle for mem_access_ctrl.
// The slave modport is the controller; the master modport is the pipeline plus memory.
interface mem_access_ctrl_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] w_data;
  logic        freeze;
  logic        ready;
  logic        addr_fault;
  logic [31:0] r_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_r_en, mem_w_en, address, w_data, mem_rdata,
    input  freeze, ready, addr_fault, r_data, mem_read, mem_write, mem_address, mem_wdata
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, w_data, mem_rdata,
    output freeze, ready, addr_fault, r_data, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store controller: stalls the pipeline while strobing the data memory
// for a fixed number of wait cycles, rejecting illegal addresses without touching memory.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned MEM_BYTES   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_ctrl_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_CYCLES - 1);
  localparam logic [31:0]     AddrLo  = 32'(BASE_ADDR);
  localparam logic [31:0]     AddrHi  = 32'(BASE_ADDR + MEM_BYTES - 4);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     r_data_q, r_data_d;
  logic            write_q, write_d;
  logic            fault_q, fault_d;

  logic        req, legal;
  logic        freeze, ready, addr_fault, mem_read, mem_write;
  logic [31:0] mem_address, mem_wdata;

  assign req   = bus.mem_r_en | bus.mem_w_en;
  assign legal = (bus.address[1:0] == 2'b00) && (bus.address >= AddrLo) &&
                 (bus.address <= AddrHi) && (bus.mem_r_en ^ bus.mem_w_en);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    r_data_d    = r_data_q;
    write_d     = write_q;
    fault_d     = fault_q;
    freeze      = 1'b0;
    ready       = 1'b0;
    addr_fault  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          freeze  = 1'b1;
          addr_d  = bus.address;
          wdata_d = bus.w_data;
          write_d = bus.mem_w_en;
          fault_d = ~legal;
          cnt_d   = CntLoad;
          if (legal) begin
            state_d = StBusy;
          end else begin
            // Clear now so the zeroed result is already visible during DONE.
            r_data_d = '0;
            state_d  = StDone;
          end
        end
      end
      StBusy: begin
        freeze      = 1'b1;
        mem_address = addr_q;
        mem_wdata   = wdata_q;
        mem_read    = ~write_q;
        // Single-cycle write strobe gives exactly one negedge commit per store.
        mem_write   = write_q && (cnt_q == '0);
        cnt_d       = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = StDone;
          if (!write_q) r_data_d = bus.mem_rdata;
        end
      end
      StDone: begin
        ready      = 1'b1;
        addr_fault = fault_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      r_data_q <= '0;
      write_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      r_data_q <= r_data_d;
      write_q  <= write_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.freeze      = freeze;
  assign bus.ready       = ready;
  assign bus.addr_fault  = addr_fault;
  assign bus.r_data      = r_data_q;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.mem_address = mem_address;
  assign bus.mem_wdata   = mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized and directed bench for mem_access_ctrl with a byte-array memory and a
// transaction-level reference model of timing, legality and returned data.
module tb_mem_access_ctrl;
  localparam int unsigned W     = 4;
  localparam int unsigned BASE  = 1024;
  localparam int unsigned BYTES = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(
    .WAIT_CYCLES(W),
    .BASE_ADDR  (BASE),
    .MEM_BYTES  (BYTES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Data memory: big-endian word view, write committed on the falling edge.
  logic [7:0]  mem [0:BYTES-1];
  logic [31:0] mem_off;
  logic        poke_en = 1'b0;
  logic [5:0]  poke_off = '0;
  logic [31:0] poke_word = '0;

  assign mem_off = bus.mem_address - 32'(BASE);
  assign bus.mem_rdata = (mem_off <= 32'(BYTES - 4)) ?
      {mem[mem_off[5:0]], mem[mem_off[5:0] + 6'd1], mem[mem_off[5:0] + 6'd2],
       mem[mem_off[5:0] + 6'd3]} : 32'h0;

  always @(negedge clk) begin
    if (bus.mem_write && mem_off <= 32'(BYTES - 4)) begin
      mem[mem_off[5:0]]        <= bus.mem_wdata[31:24];
      mem[mem_off[5:0] + 6'd1] <= bus.mem_wdata[23:16];
      mem[mem_off[5:0] + 6'd2] <= bus.mem_wdata[15:8];
      mem[mem_off[5:0] + 6'd3] <= bus.mem_wdata[7:0];
    end else if (poke_en) begin
      mem[poke_off]        <= poke_word[31:24];
      mem[poke_off + 6'd1] <= poke_word[23:16];
      mem[poke_off + 6'd2] <= poke_word[15:8];
      mem[poke_off + 6'd3] <= poke_word[7:0];
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [0:BYTES-1];
  logic [31:0] exp_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input longint addr);
    int o;
    o = int'(addr - longint'(BASE));
    return {ref_mem[o], ref_mem[o+1], ref_mem[o+2], ref_mem[o+3]};
  endfunction

  function automatic bit ref_legal(input bit r, input bit w, input longint addr);
    return (r != w) && (addr % 4 == 0) && (addr >= longint'(BASE)) &&
           (addr + 4 <= longint'(BASE + BYTES));
  endfunction

  // Writes memory and model; call only while the controller is idle.
  task automatic poke(input int unsigned addr, input logic [31:0] word);
    int o;
    o = int'(addr - BASE);
    poke_off  = o[5:0];
    poke_word = word;
    poke_en   = 1'b1;
    @(negedge clk);
    #1 poke_en = 1'b0;
    {ref_mem[o], ref_mem[o+1], ref_mem[o+2], ref_mem[o+3]} = word;
  endtask

  // Starts at posedge+1; holds the request through DONE, as the stalled pipeline would.
  task automatic run_txn(input string tag, input bit r, input bit w,
                         input logic [31:0] addr, input logic [31:0] data);
    bit legal;
    int fz = 0, rd = 0, wr = 0, wr_cyc = -1, rdy_cyc = -1;
    logic flt = 1'b0;
    legal = ref_legal(r, w, longint'(addr));
    if (!legal) exp_rdata = '0;
    else if (r) exp_rdata = ref_word(longint'(addr));
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.address  = addr;
    bus.w_data   = data;
    for (int cyc = 0; cyc < int'(W) + 6; cyc++) begin
      @(negedge clk);
      if (bus.freeze) fz++;
      if (bus.mem_read) rd++;
      if (bus.mem_write) begin
        wr++;
        wr_cyc = cyc;
        check_eq({tag, "_waddr"}, bus.mem_address, addr);
        check_eq({tag, "_wdata"}, bus.mem_wdata, data);
      end
      if (bus.ready) begin
        rdy_cyc = cyc;
        flt = bus.addr_fault;
        check_eq({tag, "_rdata"}, bus.r_data, exp_rdata);
        check_eq({tag, "_done_maddr"}, bus.mem_address, 32'h0);
      end
      @(posedge clk);
      #1;
      if (rdy_cyc >= 0) break;
    end
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    if (legal && w) begin
      for (int i = 0; i < 4; i++) ref_mem[int'(addr - BASE) + i] = data[31-8*i -: 8];
    end
    check_eq({tag, "_ready_cyc"}, rdy_cyc, legal ? W + 1 : 1);
    check_eq({tag, "_freeze_n"}, fz, legal ? W + 1 : 1);
    check_eq({tag, "_read_n"}, rd, (legal && r) ? W : 0);
    check_eq({tag, "_write_n"}, wr, (legal && w) ? 1 : 0);
    check_eq({tag, "_write_cyc"}, wr_cyc, (legal && w) ? W : 32'hffff_ffff);
    check_eq({tag, "_fault"}, flt, !legal);
    @(negedge clk);
    check_eq({tag, "_no_retrigger"}, bus.freeze, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ready_n, read_n, frz_n;
    logic [31:0] a, d;
    bit r, w;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.address  = '0;
    bus.w_data   = '0;
    for (int i = 0; i < int'(BYTES) / 4; i++) poke(BASE + 4 * i, $urandom);

    check_eq("rst_freeze", bus.freeze, 1'b0);
    check_eq("rst_ready", bus.ready, 1'b0);
    check_eq("rst_rdata", bus.r_data, 32'h0);
    check_eq("rst_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    poke(1028, 32'h1122_3344);
    @(posedge clk);
    #1;
    run_txn("load1028", 1, 0, 1028, 0);
    check_eq("load1028_value", bus.r_data, 32'h1122_3344);

    run_txn("st1040", 0, 1, 1040, 32'hDEAD_BEEF);
    run_txn("ld1040", 1, 0, 1040, 0);
    check_eq("ld1040_value", bus.r_data, 32'hDEAD_BEEF);

    run_txn("mis1042", 1, 0, 1042, 0);
    run_txn("hi1088", 1, 0, 1088, 0);
    run_txn("lo1020", 0, 1, 1020, 32'h1234_5678);
    run_txn("both1032", 1, 1, 1032, 32'h5555_AAAA);

    poke(1084, 32'hA5B6_C7D8);
    @(posedge clk);
    #1;
    run_txn("ld1084", 1, 0, 1084, 0);
    check_eq("ld1084_value", bus.r_data, 32'hA5B6_C7D8);
    run_txn("st1085", 0, 1, 1085, 32'h0BAD_0BAD);

    // Reset during the second BUSY cycle of a store
    bus.mem_w_en = 1'b1;
    bus.address  = 1048;
    bus.w_data   = 32'hCAFE_F00D;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.mem_w_en = 1'b0;
    #1;
    check_eq("rst_busy_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
    check_eq("rst_busy_freeze", bus.freeze, 1'b0);
    check_eq("rst_busy_rdata", bus.r_data, 32'h0);
    exp_rdata = '0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_idle", {bus.freeze, bus.ready}, 2'b00);
    run_txn("ld1048", 1, 0, 1048, 0);

    // Request held across two instructions: exactly two accesses
    ready_n = 0; read_n = 0; frz_n = 0;
    exp_rdata = ref_word(1056);
    bus.mem_r_en = 1'b1;
    bus.address  = 1056;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (bus.ready) begin
        ready_n++;
        check_eq("b2b_rdata", bus.r_data, exp_rdata);
      end
      if (bus.mem_read) read_n++;
      if (bus.freeze) frz_n++;
      @(posedge clk);
      #1;
      if (ready_n == 2) bus.mem_r_en = 1'b0;
    end
    check_eq("b2b_ready_n", ready_n, 2);
    check_eq("b2b_read_n", read_n, 2 * W);
    check_eq("b2b_freeze_n", frz_n, 2 * (W + 1));

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin r = 1; w = 0; end
        3, 4:    begin r = 0; w = 1; end
        default: begin r = 1; w = 1; end
      endcase
      case ($urandom_range(0, 3))
        0, 1:    a = BASE + 4 * $urandom_range(0, BYTES / 4 - 1);
        2:       a = BASE + $urandom_range(0, BYTES - 1);
        default: a = BASE - 32 + 4 * $urandom_range(0, 31);
      endcase
      d = $urandom;
      run_txn($sformatf("rnd%0d", t), r, w, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
